// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial sequencer for one external single-digit BCD adder, packed DIGITS-wide operands.
// Latency: start accepted at edge T, digits captured at T+1..T+DIGITS, done pulses the cycle after.
// Backpressure: none; start is only sampled in IDLE and ignored while busy. Optional BCD_CHECK_EN adds err.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a_in,
  input  logic [4*DIGITS-1:0]   b_in,
  input  logic                  cin,
  output logic [3:0]            dig_a,
  output logic [3:0]            dig_b,
  output logic                  dig_c,
  input  logic [3:0]            dig_s,
  input  logic                  dig_cout,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  busy,
  output logic                  done
`ifdef BCD_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  // Operands are shifted right one digit per RUN cycle so the current digit is always bits [3:0].
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic           carry;
  logic [IW-1:0]  idx;
  logic           last;
  logic           accept;

  assign last   = (idx == IW'(DIGITS - 1));
  assign accept = (state == IDLE) && start;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and adder-facing outputs; digit lanes are forced to zero outside RUN.
  always_comb begin
    state_nxt = state;
    dig_a     = 4'd0;
    dig_b     = 4'd0;
    dig_c     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        dig_a = a_sh[3:0];
        dig_b = b_sh[3:0];
        dig_c = carry;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch, digit shift, carry chain and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a_in;
      b_sh  <= b_in;
      carry <= cin;
      idx   <= '0;
    end else if (state == RUN) begin
      sum[4*idx +: 4] <= dig_s;
      carry           <= dig_cout;
      a_sh            <= {4'd0, a_sh[W-1:4]};
      b_sh            <= {4'd0, b_sh[W-1:4]};
      // idx holds at the last digit rather than wrapping; it is reloaded on the next accept.
      if (last) begin
        cout <= dig_cout;
      end else begin
        idx  <= idx + 1'b1;
      end
    end
  end

`ifdef BCD_CHECK_EN
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  // Invalid-digit flag, evaluated on the operands as they are accepted and held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= has_bad_digit(a_in) | has_bad_digit(b_in);
    end
  end
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl with a behavioural single-digit BCD adder.
// Latency and result are checked against a decimal-arithmetic reference model.
// Stimulus is a directed sequence followed by randomized valid-BCD adds.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          cin;
  logic [3:0]    dig_a;
  logic [3:0]    dig_b;
  logic          dig_c;
  logic [3:0]    dig_s;
  logic          dig_cout;
  logic [W-1:0]  sum;
  logic          cout;
  logic          busy;
  logic          done;
`ifdef BCD_CHECK_EN
  logic          err;
`endif

  int checks   = 0;
  int failures = 0;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin      (cin),
    .dig_a    (dig_a),
    .dig_b    (dig_b),
    .dig_c    (dig_c),
    .dig_s    (dig_s),
    .dig_cout (dig_cout),
    .sum      (sum),
    .cout     (cout),
    .busy     (busy),
`ifdef BCD_CHECK_EN
    .err      (err),
`endif
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-digit BCD adder: binary add, then +6 correction when the digit exceeds 9.
  logic [4:0] raw;
  always_comb begin
    raw = 5'(dig_a) + 5'(dig_b) + 5'(dig_c);
    if (raw > 5'd9) begin
      dig_s    = raw[3:0] + 4'd6;
      dig_cout = 1'b1;
    end else begin
      dig_s    = raw[3:0];
      dig_cout = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: convert to integers, add in decimal, split back into packed digits.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    longint va, vb, s, m;
    logic [W-1:0] r;
    logic co;
    va = 0; vb = 0; m = 1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      va = va * 10 + longint'(a[4*i +: 4]);
      vb = vb * 10 + longint'(b[4*i +: 4]);
      m  = m * 10;
    end
    s  = va + vb + longint'(c);
    co = (s >= m);
    s  = s % m;
    r  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return {co, r};
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) begin
      v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit chk_res);
    logic [W:0] exp_r;
    int lat;
    bit got;
`ifdef BCD_CHECK_EN
    bit exp_err;
    exp_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) exp_err = 1'b1;
    end
`endif
    exp_r = ref_add(a, b, c);
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    cin   = 1'($urandom);
    got = 1'b0;
    lat = -1;
    for (int k = 0; k < DIGITS + 8 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = k;
      end else if (k < DIGITS) begin
        chk("dig_a", dig_a, a[4*k +: 4]);
        chk("dig_b", dig_b, b[4*k +: 4]);
        chk("busy_run", busy, 1);
        if (k == 0) chk("dig_c_first", dig_c, c);
`ifdef BCD_CHECK_EN
        if (k == 0) chk("err_at_accept", err, exp_err);
`endif
      end
    end
    chk("done_seen", got, 1);
    chk("latency", lat, DIGITS);
    if (chk_res) begin
      chk("sum", sum, exp_r[W-1:0]);
      chk("cout", cout, exp_r[W]);
    end
`ifdef BCD_CHECK_EN
    chk("err_hold", err, exp_err);
`endif
  endtask

  int busy_cnt;
  int done_cnt;
  logic [W:0] held;

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_dig", {dig_a, dig_b, dig_c}, 0);
`ifdef BCD_CHECK_EN
    chk("rst_err", err, 0);
`endif
    rst = 1'b0;

    do_add(16'h1234, 16'h5678, 1'b0, 1'b1);
    chk("t1_sum", sum, 16'h6912);
    chk("t1_cout", cout, 0);

    do_add(16'h9999, 16'h0001, 1'b0, 1'b1);
    chk("t2_sum", sum, 16'h0000);
    chk("t2_cout", cout, 1);

    do_add(16'h0000, 16'h0000, 1'b1, 1'b1);
    chk("t3a_sum", sum, 16'h0001);
    chk("t3a_cout", cout, 0);
    do_add(16'h5000, 16'h5000, 1'b0, 1'b1);
    chk("t3b_sum", sum, 16'h0000);
    chk("t3b_cout", cout, 1);

    // start held high through RUN with a_in changing every cycle
    @(negedge clk);
    a_in = 16'h4321; b_in = 16'h1111; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < DIGITS + 3; k++) begin
      @(negedge clk);
      a_in = W'($urandom);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("t4_busy_cycles", busy_cnt, DIGITS + 1);
    chk("t4_done_pulses", done_cnt, 1);
    chk("t4_sum", sum, 16'h5432);
    chk("t4_cout", cout, 0);

    // reset during the second RUN cycle
    @(negedge clk);
    a_in = 16'h1111; b_in = 16'h2222; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_sum", sum, 0);
    chk("t5_cout", cout, 0);
    chk("t5_done", done, 0);
    rst = 1'b0;
    done_cnt = 0;
    repeat (DIGITS + 3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("t5_no_done", done_cnt, 0);
    do_add(16'h0456, 16'h0789, 1'b0, 1'b1);
    chk("t5_fresh_sum", sum, 16'h1245);

    // randomized valid adds
    for (int n = 0; n < 12; n++) begin
      do_add(rand_bcd(), rand_bcd(), 1'($urandom), 1'b1);
    end

    // result held through IDLE while inputs wander
    do_add(16'h8765, 16'h4321, 1'b1, 1'b1);
    held = ref_add(16'h8765, 16'h4321, 1'b1);
    repeat (4) begin
      @(negedge clk);
      a_in = W'($urandom);
      b_in = W'($urandom);
    end
    chk("hold_sum", sum, held[W-1:0]);
    chk("hold_cout", cout, held[W]);
    chk("hold_idle_dig", {dig_a, dig_b, dig_c}, 0);

`ifdef BCD_CHECK_EN
    do_add(16'h12A4, 16'h0001, 1'b0, 1'b0);
    chk("t6_err_set", err, 1);
    do_add(16'h0001, 16'h0002, 1'b0, 1'b1);
    chk("t6_err_clear", err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
